// File: rtl/ble_exmem_arb_if.sv
// ============================================================================
// Module      : ble_exmem_arb_if
// Description : Bundle of the two requester ports and the external-memory port
//               shared by ble_exmem_arb.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ble_exmem_arb_if;
  // m0: packet/descriptor engine (real-time)
  logic        m0_req;
  logic [3:0]  m0_we;
  logic [22:0] m0_adr;
  logic [31:0] m0_wdat;
  logic [31:0] m0_rdat;
  logic        m0_ack;
  logic        m0_err;
  // m1: CPU/SFR bridge (background)
  logic        m1_req;
  logic [3:0]  m1_we;
  logic [22:0] m1_adr;
  logic [31:0] m1_wdat;
  logic [31:0] m1_rdat;
  logic        m1_ack;
  logic        m1_err;
  // shared external-memory port
  logic        ex_mem_req;
  logic [3:0]  ex_mem_we;
  logic [22:0] ex_mem_adr;
  logic [31:0] ex_mem_wdat;
  logic [31:0] ex_mem_rdat;
  logic        ex_mem_ack;

  // arbiter side: serves the requesters, drives the memory command
  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdat,
    output m0_rdat, m0_ack, m0_err,
    input  m1_req, m1_we, m1_adr, m1_wdat,
    output m1_rdat, m1_ack, m1_err,
    output ex_mem_req, ex_mem_we, ex_mem_adr, ex_mem_wdat,
    input  ex_mem_rdat, ex_mem_ack
  );

  // environment side: requesters plus the memory responder
  modport master (
    output m0_req, m0_we, m0_adr, m0_wdat,
    input  m0_rdat, m0_ack, m0_err,
    output m1_req, m1_we, m1_adr, m1_wdat,
    input  m1_rdat, m1_ack, m1_err,
    input  ex_mem_req, ex_mem_we, ex_mem_adr, ex_mem_wdat,
    output ex_mem_rdat, ex_mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/ble_exmem_arb.sv
// ============================================================================
// Module      : ble_exmem_arb
// Description : Two-requester arbiter for the BLE external-memory port with
//               ack watchdog. Define BLE_EXMEM_RR_EN for round-robin
//               arbitration; otherwise m0 has fixed priority.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ble_exmem_arb #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  wire              bsb_clk,
  input  wire              ble_rst,
  ble_exmem_arb_if.slave   bus,
  output logic             timeout_int
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam bit              WD_EN = (ACK_TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LIM = TO_W'(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] WD_MAX = {TO_W{1'b1}};

  state_e            state_q, state_d;
  logic              ex_req_q, ex_req_d;
  logic [3:0]        ex_we_q, ex_we_d;
  logic [22:0]       ex_adr_q, ex_adr_d;
  logic [31:0]       ex_wdat_q, ex_wdat_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic [1:0]        err_q, err_d;
  logic              tint_q, tint_d;

  logic [1:0]        req_vec;
  logic              win1;
  logic              wd_expired;

  assign req_vec    = {bus.m1_req, bus.m0_req};
  assign wd_expired = WD_EN && (wd_q == WD_LIM);

`ifdef BLE_EXMEM_RR_EN
  // last_q = 1 means m1 held the most recent grant; reset favours m0.
  logic last_q, last_d;

  always_comb begin
    win1 = req_vec[1] & (~req_vec[0] | ~last_q);
  end

  always_ff @(posedge bsb_clk or posedge ble_rst) begin
    if (ble_rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && (|req_vec)) begin
      last_d = win1;
    end
  end
`else
  always_comb begin
    win1 = req_vec[1] & ~req_vec[0];
  end
`endif

  always_ff @(posedge bsb_clk or posedge ble_rst) begin
    if (ble_rst) begin
      state_q   <= ST_IDLE;
      ex_req_q  <= 1'b0;
      ex_we_q   <= 4'h0;
      ex_adr_q  <= 23'h0;
      ex_wdat_q <= 32'h0;
      wd_q      <= '0;
      err_q     <= 2'b00;
      tint_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ex_req_q  <= ex_req_d;
      ex_we_q   <= ex_we_d;
      ex_adr_q  <= ex_adr_d;
      ex_wdat_q <= ex_wdat_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      tint_q    <= tint_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ex_req_d  = ex_req_q;
    ex_we_d   = ex_we_q;
    ex_adr_d  = ex_adr_q;
    ex_wdat_d = ex_wdat_q;
    wd_d      = wd_q;
    err_d     = 2'b00;
    tint_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          ex_req_d = 1'b1;
          wd_d     = '0;
          if (win1) begin
            ex_we_d   = bus.m1_we;
            ex_adr_d  = bus.m1_adr;
            ex_wdat_d = bus.m1_wdat;
            state_d   = ST_GNT1;
          end else begin
            ex_we_d   = bus.m0_we;
            ex_adr_d  = bus.m0_adr;
            ex_wdat_d = bus.m0_wdat;
            state_d   = ST_GNT0;
          end
        end
      end

      ST_GNT0, ST_GNT1: begin
        // An ack landing on the expiry cycle completes the access normally.
        if (bus.ex_mem_ack) begin
          ex_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (wd_expired) begin
          ex_req_d = 1'b0;
          state_d  = ST_IDLE;
          tint_d   = 1'b1;
          err_d    = (state_q == ST_GNT1) ? 2'b10 : 2'b01;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      default: begin
        ex_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Responses are combinational from memory, gated to the granted requester.
  assign bus.m0_ack  = (state_q == ST_GNT0) & bus.ex_mem_ack;
  assign bus.m1_ack  = (state_q == ST_GNT1) & bus.ex_mem_ack;
  assign bus.m0_rdat = (state_q == ST_GNT0) ? bus.ex_mem_rdat : 32'h0;
  assign bus.m1_rdat = (state_q == ST_GNT1) ? bus.ex_mem_rdat : 32'h0;
  assign bus.m0_err  = err_q[0];
  assign bus.m1_err  = err_q[1];

  assign bus.ex_mem_req  = ex_req_q;
  assign bus.ex_mem_we   = ex_we_q;
  assign bus.ex_mem_adr  = ex_adr_q;
  assign bus.ex_mem_wdat = ex_wdat_q;
  assign timeout_int     = tint_q;

endmodule

`default_nettype wire

// File: tb/tb_ble_exmem_arb.sv
// ============================================================================
// Module      : tb_ble_exmem_arb
// Description : Randomized self-checking bench for ble_exmem_arb against a
//               transaction-level arbitration/timeout model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ble_exmem_arb;

  localparam int TMO = 4;
`ifdef BLE_EXMEM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timeout_int;

  ble_exmem_arb_if bus ();

  ble_exmem_arb #(.ACK_TIMEOUT(TMO), .TO_W(8)) dut (
    .bsb_clk     (clk),
    .ble_rst     (rst),
    .bus         (bus.slave),
    .timeout_int (timeout_int)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: pending requests, their commands and the last grant.
  bit          pend [2];
  logic [3:0]  cwe  [2];
  logic [22:0] cadr [2];
  logic [31:0] cwd  [2];
  bit          last = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    bus.m0_req = pend[0]; bus.m0_we = cwe[0]; bus.m0_adr = cadr[0]; bus.m0_wdat = cwd[0];
    bus.m1_req = pend[1]; bus.m1_we = cwe[1]; bus.m1_adr = cadr[1]; bus.m1_wdat = cwd[1];
  endtask

  task automatic new_req(input int n, input logic [3:0] we, input logic [22:0] adr, input logic [31:0] wd);
    pend[n] = 1'b1; cwe[n] = we; cadr[n] = adr; cwd[n] = wd;
    drive();
  endtask

  task automatic rnd_req(input int n);
    logic [3:0]  we;
    logic [22:0] adr;
    we  = 4'($urandom);
    adr = 23'($urandom);
    new_req(n, we, adr, $urandom);
  endtask

  function automatic logic [31:0] ack_of(input int n);
    return (n == 0) ? 32'(bus.m0_ack) : 32'(bus.m1_ack);
  endfunction
  function automatic logic [31:0] err_of(input int n);
    return (n == 0) ? 32'(bus.m0_err) : 32'(bus.m1_err);
  endfunction
  function automatic logic [31:0] rdat_of(input int n);
    return (n == 0) ? bus.m0_rdat : bus.m1_rdat;
  endfunction

  // Called in an IDLE cycle after its negedge; returns in the following
  // IDLE cycle after its negedge. lat = GNT cycle index of the memory ack.
  task automatic do_access(input int lat, input logic [31:0] rd, input bit idle_ack,
                           input bit drop, output int w, output logic [22:0] adr0);
    logic [31:0] rv;
    bit          tmo;
    bus.ex_mem_ack = 1'b0;
    if (pend[0] && pend[1]) w = RR ? (last ? 0 : 1) : 0;
    else                    w = pend[0] ? 0 : 1;
    last = (w == 1);
    tmo  = (lat > TMO);
    @(posedge clk); #1;
    if (drop) begin pend[w] = 1'b0; drive(); end
    for (int i = 0; i <= TMO; i++) begin
      if (i == lat) begin rv = rd; bus.ex_mem_ack = 1'b1; end
      else          begin rv = $urandom; bus.ex_mem_ack = 1'b0; end
      bus.ex_mem_rdat = rv;
      @(negedge clk);
      if (i == 0) adr0 = bus.ex_mem_adr;
      check("gnt_req", 32'(bus.ex_mem_req), 1);
      check("gnt_we", 32'(bus.ex_mem_we), 32'(cwe[w]));
      check("gnt_adr", 32'(bus.ex_mem_adr), 32'(cadr[w]));
      check("gnt_wdat", bus.ex_mem_wdat, cwd[w]);
      check("win_ack", ack_of(w), (i == lat) ? 1 : 0);
      check("win_rdat", rdat_of(w), rv);
      check("lose_ack", ack_of(1 - w), 0);
      check("lose_rdat", rdat_of(1 - w), 0);
      check("gnt_err", {err_of(1), err_of(0)}, 0);
      check("gnt_tint", 32'(timeout_int), 0);
      @(posedge clk); #1;
      if (i == lat) break;
    end
    bus.ex_mem_ack = 1'b0;
    pend[w] = 1'b0;
    drive();
    if (idle_ack) begin bus.ex_mem_ack = 1'b1; bus.ex_mem_rdat = $urandom; end
    @(negedge clk);
    check("idle_req", 32'(bus.ex_mem_req), 0);
    check("idle_err_w", err_of(w), 32'(tmo));
    check("idle_err_l", err_of(1 - w), 0);
    check("idle_tint", 32'(timeout_int), 32'(tmo));
    check("idle_ack", {ack_of(1), ack_of(0)}, 0);
    check("idle_rdat", rdat_of(0) | rdat_of(1), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.ex_mem_req), 0);
    check({tag, "_we"}, 32'(bus.ex_mem_we), 0);
    check({tag, "_adr"}, 32'(bus.ex_mem_adr), 0);
    check({tag, "_wdat"}, bus.ex_mem_wdat, 0);
    check({tag, "_ack"}, {ack_of(1), ack_of(0)}, 0);
    check({tag, "_err"}, {err_of(1), err_of(0)}, 0);
    check({tag, "_rdat"}, rdat_of(0) | rdat_of(1), 0);
    check({tag, "_tint"}, 32'(timeout_int), 0);
  endtask

  int          w;
  logic [22:0] a0;
  bit          exp_ord [4];

  initial begin
    for (int n = 0; n < 2; n++) begin pend[n] = 0; cwe[n] = 0; cadr[n] = 0; cwd[n] = 0; end
    drive();
    bus.ex_mem_ack  = 1'b0;
    bus.ex_mem_rdat = 32'h0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // single m0 write, memory acks 3 cycles after ex_mem_req
    new_req(0, 4'hF, 23'h000100, 32'hA5A5_5A5A);
    do_access(3, 32'h1234_5678, 1'b0, 1'b0, w, a0);
    check("wr_adr", 32'(a0), 32'h100);

    // m1 read of the top address
    new_req(1, 4'h0, 23'h7FFFFF, 32'h0);
    do_access(0, 32'hDEAD_BEEF, 1'b0, 1'b0, w, a0);
    check("rd_winner", 32'(w), 1);

    // simultaneous requests, winner re-requests each time
    for (int i = 0; i < 4; i++) exp_ord[i] = RR ? (i % 2 == 1) : 1'b0;
    new_req(0, 4'h1, 23'h000111, 32'h0000_0111);
    new_req(1, 4'h2, 23'h000222, 32'h0000_0222);
    for (int i = 0; i < 4; i++) begin
      do_access(0, $urandom, 1'b0, 1'b0, w, a0);
      check("order", 32'(a0), exp_ord[i] ? 32'h222 : 32'h111);
      if (i < 3) begin
        if (w == 0) new_req(0, 4'h1, 23'h000111, 32'h0000_0111);
        else        new_req(1, 4'h2, 23'h000222, 32'h0000_0222);
      end
    end
    for (int k = 0; k < 2 && (pend[0] || pend[1]); k++)
      do_access(1, $urandom, 1'b0, 1'b0, w, a0);

    // timeout with late ack, then ack on the expiry cycle
    new_req(0, 4'h3, 23'h0ABCDE, 32'hCAFE_0001);
    do_access(TMO + 2, $urandom, 1'b1, 1'b0, w, a0);
    new_req(0, 4'h0, 23'h012345, 32'h0);
    do_access(TMO, 32'h0BAD_F00D, 1'b0, 1'b0, w, a0);

    // reset mid-grant of m1
    new_req(1, 4'hC, 23'h055555, 32'h5555_AAAA);
    @(posedge clk); #1;
    bus.ex_mem_ack = 1'b1; bus.ex_mem_rdat = 32'hFFFF_0000;
    @(negedge clk);
    check("mid_ack_pre", 32'(bus.m1_ack), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    pend[0] = 0; pend[1] = 0; drive();
    bus.ex_mem_ack = 1'b0;
    last = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_post");
    new_req(1, 4'h6, 23'h033333, 32'h3333_CCCC);
    do_access(2, 32'h7777_8888, 1'b0, 1'b0, w, a0);
    check("after_rst_win", 32'(w), 1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) rnd_req(0);
      if (!pend[1] && $urandom_range(0, 1) == 1) rnd_req(1);
      if (!pend[0] && !pend[1]) rnd_req(int'($urandom_range(0, 1)));
      do_access(int'($urandom_range(0, TMO + 2)), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, w, a0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
